// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator/checker: default width,
// parity-sense constants and a width-generic population count.
package parity_pkg;

  localparam int DATA_W    = 8;
  localparam bit PAR_EVEN  = 1'b0;
  localparam bit PAR_ODD   = 1'b1;

  // Widest word popcount accepts; narrower words are zero-extended by the caller.
  localparam int MAX_POP_W = 256;

  function automatic int unsigned popcount(input logic [MAX_POP_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_POP_W; i++) begin
      cnt += {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational reduction of a data word into its XOR parity and its
// count of set bits.
module parity_reduce
  import parity_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  output logic             par,
  output logic [CW-1:0]    cnt
);

  logic [MAX_POP_W-1:0] ext;

  always_comb begin
    ext            = '0;
    ext[WIDTH-1:0] = a;
    par            = ^a;
    cnt            = CW'(popcount(ext));
  end

endmodule

// File: rtl/parity1_unit.sv
// Registered parity generator/checker: on each enabled edge captures the
// parity bit and ones count of the input word and pulses vld for one cycle.
module parity1_unit
  import parity_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter bit ODD   = PAR_EVEN,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic             en,
  output logic             chk,
  output logic             vld,
  output logic [CW-1:0]    ones
);

  logic          par;
  logic [CW-1:0] cnt;

  parity_reduce #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_reduce (
    .a  (a),
    .par(par),
    .cnt(cnt)
  );

  // Results only load on enabled edges, so a (even if X) is ignored while en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk  <= 1'b0;
      vld  <= 1'b0;
      ones <= '0;
    end else begin
      vld <= en;
      if (en) begin
        chk  <= par ^ ODD;
        ones <= cnt;
      end
    end
  end

endmodule

// File: tb/tb_parity1_unit.sv
// Directed self-checking bench for parity1_unit: even and odd-sense
// instances driven from a shared vector table plus reset sequences.
module tb_parity1_unit;
  import parity_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic       chk, vld;
  logic [3:0] ones;
  logic       oddChk, oddVld;
  logic [3:0] oddOnes;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] a;
    logic       en;
    logic       expChk;
    logic [3:0] expOnes;
    logic       expVld;
    logic       expOddChk;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  parity1_unit #(.WIDTH(8), .ODD(PAR_EVEN)) dut_even (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .en  (en),
    .chk (chk),
    .vld (vld),
    .ones(ones)
  );

  parity1_unit #(.WIDTH(8), .ODD(PAR_ODD)) dut_odd (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .en  (en),
    .chk (oddChk),
    .vld (oddVld),
    .ones(oddOnes)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] va, input logic ven);
    @(negedge clk);
    a  = va;
    en = ven;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [7:0] va, input logic ven, input logic c,
                        input logic [3:0] o, input logic v, input logic oc);
    vec_t t;
    t.a = va; t.en = ven; t.expChk = c; t.expOnes = o; t.expVld = v; t.expOddChk = oc;
    vecs.push_back(t);
  endtask

  task automatic checkAll(input string tag, input logic c, input logic [3:0] o,
                          input logic v, input logic oc);
    checkOutput({tag, " chk"}, {31'd0, chk}, {31'd0, c});
    checkOutput({tag, " ones"}, {28'd0, ones}, {28'd0, o});
    checkOutput({tag, " vld"}, {31'd0, vld}, {31'd0, v});
    checkOutput({tag, " oddChk"}, {31'd0, oddChk}, {31'd0, oc});
    checkOutput({tag, " oddOnes"}, {28'd0, oddOnes}, {28'd0, o});
    checkOutput({tag, " oddVld"}, {31'd0, oddVld}, {31'd0, v});
  endtask

  initial begin
    //      a        en    chk   ones   vld   oddChk
    addVec(8'hAD, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    addVec(8'hAD, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) addVec(8'h00, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    addVec(8'h1E, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1);
    addVec(8'h1E, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1);
    addVec(8'hFF, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1);
    addVec(8'h01, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
    addVec(8'h03, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1);
    addVec(8'h07, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
    addVec(8'hxx, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    addVec(8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    addVec(8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    rst = 1'b1;
    en  = 1'b0;
    a   = 8'h00;
    #2;
    checkAll("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].en);
      checkAll($sformatf("vec%0d", i), vecs[i].expChk, vecs[i].expOnes,
               vecs[i].expVld, vecs[i].expOddChk);
    end

    // Asynchronous reset mid-run with a capture pending on the next edge
    applyStimulus(8'hAD, 1'b1);
    checkAll("preRst", 1'b1, 4'd5, 1'b1, 1'b0);
    @(negedge clk);
    a  = 8'hFF;
    en = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkAll("asyncRst", 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkAll("rstHeld", 1'b0, 4'd0, 1'b0, 1'b0);

    // Capture on the very first edge after release
    @(negedge clk);
    rst = 1'b0;
    a   = 8'hAD;
    en  = 1'b1;
    @(posedge clk);
    #1;
    checkAll("firstEdge", 1'b1, 4'd5, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkAll("afterFirst", 1'b1, 4'd5, 1'b0, 1'b0);

    // Odd-sense boundaries
    applyStimulus(8'h00, 1'b1);
    checkAll("zeroWord", 1'b0, 4'd0, 1'b1, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    checkAll("onesWord", 1'b0, 4'd8, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
